pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_if.sv | 28 ++
 rtl/pipe_stage_reg.sv | 161 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/payload, flush,
// downstream valid/ready/payload and the stall counter readout.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Flushable pipeline stage register with bubble-safe control and stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int unsigned       CNT_W    = 8
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e            state_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;
  logic              in_ready;
  logic              in_xfer;

  assign in_xfer = bus.in_valid && in_ready;

  // Saturating count of cycles where a held entry is blocked downstream.
  assign stall_cnt_d = (out_valid_q && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
                     ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ctrl  = out_ctrl_q;
  assign bus.stall_cnt = stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN

  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic              in_ready_q;

  assign in_ready = in_ready_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= NOP_CTRL;
      skid_data_q <= '0;
      skid_ctrl_q <= NOP_CTRL;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (bus.flush) begin
        state_q     <= ST_EMPTY;
        out_valid_q <= 1'b0;
        out_ctrl_q  <= NOP_CTRL;
        in_ready_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (in_xfer) begin
              state_q     <= ST_FULL;
              out_valid_q <= 1'b1;
              out_data_q  <= bus.in_data;
              out_ctrl_q  <= bus.in_ctrl;
            end
          end
          ST_FULL: begin
            if (in_xfer && bus.out_ready) begin
              out_data_q <= bus.in_data;
              out_ctrl_q <= bus.in_ctrl;
            end else if (in_xfer) begin
              // Downstream blocked: park the new payload behind the held one.
              state_q     <= ST_SKID;
              skid_data_q <= bus.in_data;
              skid_ctrl_q <= bus.in_ctrl;
              in_ready_q  <= 1'b0;
            end else if (bus.out_ready) begin
              state_q     <= ST_EMPTY;
              out_valid_q <= 1'b0;
              out_ctrl_q  <= NOP_CTRL;
            end
          end
          ST_SKID: begin
            if (bus.out_ready) begin
              state_q    <= ST_FULL;
              out_data_q <= skid_data_q;
              out_ctrl_q <= skid_ctrl_q;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_ctrl_q  <= NOP_CTRL;
            in_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

`else

  // Single entry: ready whenever the held payload is empty or leaving.
  assign in_ready = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= NOP_CTRL;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (bus.flush) begin
        state_q     <= ST_EMPTY;
        out_valid_q <= 1'b0;
        out_ctrl_q  <= NOP_CTRL;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (in_xfer) begin
              state_q     <= ST_FULL;
              out_valid_q <= 1'b1;
              out_data_q  <= bus.in_data;
              out_ctrl_q  <= bus.in_ctrl;
            end
          end
          ST_FULL: begin
            if (in_xfer) begin
              out_data_q <= bus.in_data;
              out_ctrl_q <= bus.in_ctrl;
            end else if (bus.out_ready) begin
              state_q     <= ST_EMPTY;
              out_valid_q <= 1'b0;
              out_ctrl_q  <= NOP_CTRL;
            end
          end
          default: begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_ctrl_q  <= NOP_CTRL;
          end
        endcase
      end
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based reference model;
// a second instance with a 2-bit stall counter tracks saturation in parallel.
module tb_pipe_stage_reg;
  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 16;
  localparam int unsigned CNTW = 8;
  localparam logic [15:0] NOP  = 16'hC3C3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(CNTW)) bus();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2))    bus_s();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .CNT_W(CNTW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_data   = bus.in_data;
  assign bus_s.in_ctrl   = bus.in_ctrl;
  assign bus_s.flush     = bus.flush;
  assign bus_s.out_ready = bus.out_ready;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] c;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_data;
  int          m_stall;
  int          m_stall_s;
  bit          m_init;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || bus.out_ready;
`endif
  endfunction

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic tick();
    bit   in_x;
    bit   out_x;
    ent_t e;
    #1;
    if (m_init && rst) chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_in_ready()});
    in_x  = m_init && m_in_ready() && bus.in_valid;
    out_x = (mq.size() > 0) && bus.out_ready;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_data    = 16'h0000;
      m_stall   = 0;
      m_stall_s = 0;
      m_init    = 1'b1;
    end else begin
      if ((mq.size() > 0) && !bus.out_ready) begin
        if (m_stall < 255) m_stall++;
        if (m_stall_s < 3) m_stall_s++;
      end
      if (bus.flush) begin
        if (mq.size() > 0 || in_x) $display("flush drops %0d held entries", mq.size());
        mq.delete();
      end else begin
        if (out_x) begin
          $display("out data=%h ctrl=%h", mq[0].d, mq[0].c);
          void'(mq.pop_front());
        end
        if (in_x) begin
          e.d = bus.in_data;
          e.c = bus.in_ctrl;
          mq.push_back(e);
        end
      end
      if (mq.size() > 0) m_data = mq[0].d;
    end
    #1;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
    chk("out_data", {16'd0, bus.out_data}, {16'd0, m_data});
    if (mq.size() > 0) chk("out_ctrl", {16'd0, bus.out_ctrl}, {16'd0, mq[0].c});
    else               chk("out_ctrl_nop", {16'd0, bus.out_ctrl}, {16'd0, NOP});
    chk("stall_cnt", {24'd0, bus.stall_cnt}, m_stall);
    chk("stall_cnt_sat", {30'd0, bus_s.stall_cnt}, m_stall_s);
    chk("out_valid_s", {31'd0, bus_s.out_valid}, {31'd0, mq.size() > 0});
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input logic [15:0] c,
                       input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    m_init    = 1'b0;
    m_data    = 16'h0000;
    m_stall   = 0;
    m_stall_s = 0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset for two cycles, then release.
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, bus.out_data}, 32'h0);
    chk("rst_out_ctrl", {16'd0, bus.out_ctrl}, {16'd0, NOP});
    chk("rst_stall", {24'd0, bus.stall_cnt}, 32'd0);
    @(posedge clk); #1;

    // Single payload passes with one-cycle latency, then a bubble.
    drive(1'b1, 16'h1234, 16'h00A5, 1'b1, 1'b0);
    tick();
    chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_data", {16'd0, bus.out_data}, 32'h1234);
    chk("lat_ctrl", {16'd0, bus.out_ctrl}, 32'h00A5);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    chk("bubble_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bubble_ctrl", {16'd0, bus.out_ctrl}, {16'd0, NOP});

    // Hold an entry for five blocked cycles.
    drive(1'b1, 16'h5A5A, 16'h0011, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("stall5_data", {16'd0, bus.out_data}, 32'h5A5A);
    chk("stall5_ctrl", {16'd0, bus.out_ctrl}, 32'h0011);
    chk("stall5_cnt", {24'd0, bus.stall_cnt}, 32'd5);
    chk("stall5_sat", {30'd0, bus_s.stall_cnt}, 32'd3);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();

    // Two payloads into a blocked stage, then release.
    drive(1'b1, 16'h0001, 16'h0101, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0002, 16'h0202, 1'b0, 1'b0);
    tick();
`ifdef PIPE_STAGE_SKID_EN
    chk("skid_in_ready", {31'd0, bus.in_ready}, 32'd0);
`endif
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
`ifdef PIPE_STAGE_SKID_EN
    chk("skid_second", {16'd0, bus.out_data}, 32'h0002);
`endif
    tick();
    tick();

    // Flush a full stage while offering 0xBEEF.
    drive(1'b1, 16'h0003, 16'h0303, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0004, 16'h0404, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'hBEEF, 16'h0F0F, 1'b0, 1'b1);
    tick();
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_ctrl", {16'd0, bus.out_ctrl}, {16'd0, NOP});
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_beef", {31'd0, bus.out_valid && (bus.out_data == 16'hBEEF)}, 32'd0);
    end

    // Reset while holding two entries.
    drive(1'b1, 16'h0005, 16'h0505, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0006, 16'h0606, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    tick();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
      rst = ($urandom_range(0, 79) != 0);
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
